// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: small circular FIFO of (pc, instruction) beats between fetch and decode.
// A flush empties it at once, and decode sees a NOP bubble whenever no valid head entry exists.
module if_id_buffer #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 2,
  parameter logic [INST_WIDTH-1:0] NOP_INST   = 32'h00000013
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_enable_i,
  input  logic                    fetch_valid_i,
  output logic                    fetch_ready_o,
  input  logic [ADDR_WIDTH-1:0]   fetch_pc_i,
  input  logic [INST_WIDTH-1:0]   fetch_inst_i,
  output logic                    id_valid_o,
  input  logic                    id_ready_i,
  output logic [ADDR_WIDTH-1:0]   id_pc_o,
  output logic [INST_WIDTH-1:0]   id_inst_o,
  output logic [$clog2(DEPTH):0]  occupancy_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push;
  logic                  pop;

  // Ready looks only at the registered count, so a full buffer refuses a beat even if decode pops that cycle.
  assign fetch_ready_o = (count < DEPTH_C) & ~rst_i;
  assign id_valid_o    = (count != '0) & ~flush_enable_i;
  assign push          = fetch_valid_i & fetch_ready_o & ~flush_enable_i;
  assign pop           = id_valid_o & id_ready_i;
  assign occupancy_o   = count;

  always_comb begin
    id_pc_o   = '0;
    id_inst_o = NOP_INST;
    if (id_valid_o) begin
      id_pc_o   = pc_mem[rd_ptr];
      id_inst_o = inst_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc_i;
      inst_mem[wr_ptr] <= fetch_inst_i;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_enable_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
